// File: rtl/fpu_norm_round_ctrl.sv
// Normalise / round-to-nearest-even / pack sequencer for single-precision results.
// Takes an unpacked sign/exponent/mantissa and emits an IEEE-754 single over a valid/ready handshake.
module fpu_norm_round_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_s,
    input  logic [9:0]  in_e,
    input  logic [26:0] in_m,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_z,
    output logic        busy
);

    typedef enum logic [2:0] {StIdle, StNormL, StNormR, StRound, StPack, StDone} state_e;

    localparam logic signed [10:0] EMin = -11'sd126;
    localparam logic signed [10:0] EMax = 11'sd127;

    state_e             state_q, state_d;
    logic               s_q, s_d;
    logic signed [10:0] e_q, e_d;
    logic        [26:0] m_q, m_d;
    logic        [23:0] sig_q, sig_d;
    logic        [31:0] out_z_q, out_z_d;
    logic               out_valid_q, out_valid_d;

    logic signed [10:0] e_inc;
    logic               round_up;
    logic        [31:0] pack_z;

    assign e_inc    = e_q + 11'sd1;
    assign round_up = m_q[2] & (m_q[1] | m_q[0] | m_q[3]);

    // Infinity wins over the denormal and +0 rules.
    always_comb begin
        pack_z = {s_q, e_q[7:0] + 8'd127, sig_q[22:0]};
        if (e_q == EMin && !sig_q[23]) pack_z[30:23] = 8'h00;
        if (e_q == EMin && sig_q == 24'h0) pack_z[31] = 1'b0;
        if (e_q > EMax) pack_z = {s_q, 8'hFF, 23'h0};
    end

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        e_d         = e_q;
        m_d         = m_q;
        sig_d       = sig_q;
        out_z_d     = out_z_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    s_d     = in_s;
                    e_d     = {in_e[9], in_e};
                    m_d     = in_m;
                    state_d = StNormL;
                end
            end
            StNormL: begin
                if (!m_q[26] && e_q > EMin) begin
                    m_d = m_q << 1;
                    e_d = e_q - 11'sd1;
                end else if (e_q < EMin) begin
                    state_d = StNormR;
                end else begin
                    state_d = StRound;
                end
            end
            StNormR: begin
                // Shifted-out bits fold into sticky so rounding stays exact.
                m_d = {1'b0, m_q[26:2], m_q[1] | m_q[0]};
                e_d = e_inc;
                if (e_inc == EMin) state_d = StRound;
            end
            StRound: begin
                sig_d = m_q[26:3] + {23'd0, round_up};
                if (m_q[26:3] == 24'hFFFFFF && round_up) begin
                    sig_d = 24'h800000;
                    e_d   = e_inc;
                end
                state_d = StPack;
            end
            StPack: begin
                out_z_d     = pack_z;
                out_valid_d = 1'b1;
                state_d     = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            s_q         <= 1'b0;
            e_q         <= '0;
            m_q         <= '0;
            sig_q       <= '0;
            out_z_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            e_q         <= e_d;
            m_q         <= m_d;
            sig_q       <= sig_d;
            out_z_q     <= out_z_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign out_valid = out_valid_q;
    assign out_z     = out_z_q;

endmodule

// File: tb/tb_fpu_norm_round_ctrl.sv
// Directed bench for fpu_norm_round_ctrl with a scoreboard of expected packed results.
// Latency is counted in rising edges with the accept edge as the first.
module tb_fpu_norm_round_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_s;
    logic [9:0]  in_e;
    logic [26:0] in_m;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_z;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_z_q[$];
    int          exp_lat_q[$];

    fpu_norm_round_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_s      (in_s),
        .in_e      (in_e),
        .in_m      (in_m),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_z     (out_z),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Starts and ends on a falling edge.
    task automatic run_op(input string tag, input logic s, input logic [9:0] e,
                          input logic [26:0] m, input logic [31:0] ez, input int el,
                          input int stall);
        int          n;
        int          guard;
        logic [31:0] want_z;
        int          want_lat;
        logic [31:0] held_z;
        exp_z_q.push_back(ez);
        exp_lat_q.push_back(el);
        in_s     = s;
        in_e     = e;
        in_m     = m;
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 10) begin
            @(posedge clk);
            @(negedge clk);
            guard++;
        end
        check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        n = 1;
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        while (!out_valid && n < 300) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        want_z   = exp_z_q.pop_front();
        want_lat = exp_lat_q.pop_front();
        check({tag, "_z"}, out_z, want_z);
        check({tag, "_lat"}, n, want_lat);
        held_z = out_z;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check({tag, "_stall_z"}, out_z, held_z);
            check({tag, "_stall_valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, "_stall_ready"}, {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_s      = 1'b0;
        in_e      = '0;
        in_m      = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_z", out_z, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("one",      1'b0, 10'd0,   27'h4000000, 32'h3F800000, 4,   0);
        run_op("lnorm",    1'b0, 10'd3,   27'h1000000, 32'h40000000, 6,   0);
        run_op("negzero",  1'b1, 10'd0,   27'h0000000, 32'h00000000, 130, 0);
        run_op("carry",    1'b0, 10'd0,   27'h7FFFFFC, 32'h40000000, 4,   0);
        run_op("tie_even", 1'b0, 10'd0,   27'h4000004, 32'h3F800000, 4,   0);
        run_op("rnd_up",   1'b0, 10'd0,   27'h4000006, 32'h3F800001, 4,   0);
        run_op("ovf_pos",  1'b0, 10'd128, 27'h4000000, 32'h7F800000, 4,   0);
        run_op("ovf_neg",  1'b1, 10'd128, 27'h4000000, 32'hFF800000, 4,   0);
        run_op("ovf_rnd",  1'b0, 10'd127, 27'h7FFFFFC, 32'h7F800000, 4,   0);
        run_op("wrap511",  1'b0, 10'd511, 27'h7FFFFFC, 32'h7F800000, 4,   0);
        run_op("denorm",   1'b0, 10'h381, 27'h4000000, 32'h00400000, 5,   0);
        run_op("neg_half", 1'b1, 10'h3FF, 27'h4000000, 32'hBF000000, 4,   0);
        run_op("stall",    1'b0, 10'd1,   27'h6000000, 32'h40400000, 4,   3);

        // Abort a long left-normalise with reset.
        in_s     = 1'b0;
        in_e     = 10'd0;
        in_m     = 27'h0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_busy_pre", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_valid", {31'd0, out_valid}, 32'd0);
        check("abort_ready", {31'd0, in_ready}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_z", out_z, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("after_rst", 1'b1, 10'd2, 27'h5000000, 32'hC0A00000, 4, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
